axi_shim_ot: RTL

- Parametrised successor of the single-transaction AXI shim between the cache subsystems (I$/D$ miss and write-back units) and the AXI interconnect.
- Accepts cache-line read and write bursts of up to NumWords beats.
- AW and W are decoupled, tracked by independent flags rather than combined states.
- Outstanding read and write transactions are counted separately, up to configurable limits, and new requests stall at the limit.

---
 rtl/axi_shim_pkg.sv | 105 ++++++++++
 rtl/axi_shim_txn_cnt.sv | 45 ++++
 rtl/axi_shim_ot.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/axi_shim_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axi_shim_pkg
// Desc     : Shared constants, width helpers and default AXI structs for axi_shim_ot.
// Revision : 1.0 - initial release
// ============================================================================
package axi_shim_pkg;

  localparam logic [1:0] c_BURST_FIXED = 2'b00;
  localparam logic [1:0] c_BURST_INCR  = 2'b01;
  localparam logic [1:0] c_BURST_WRAP  = 2'b10;

  localparam logic [3:0] c_CACHE_MODIFIABLE = 4'b0010;

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_EXOKAY = 2'b01;

  localparam int unsigned c_AXI_ADDR_W = 64;
  localparam int unsigned c_AXI_DATA_W = 64;
  localparam int unsigned c_AXI_ID_W   = 4;
  localparam int unsigned c_AXI_USER_W = 1;

  // Beat-count field width: max(1, clog2(n)).
  function automatic int unsigned blen_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width able to hold 0..m inclusive.
  function automatic int unsigned cnt_width(input int unsigned m);
    return $clog2(m + 1);
  endfunction

  typedef struct packed {
    logic [c_AXI_ID_W-1:0]   id;
    logic [c_AXI_ADDR_W-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [5:0]              atop;
    logic [c_AXI_USER_W-1:0] user;
  } axi_aw_t;

  typedef struct packed {
    logic [c_AXI_DATA_W-1:0]   data;
    logic [c_AXI_DATA_W/8-1:0] strb;
    logic                      last;
    logic [c_AXI_USER_W-1:0]   user;
  } axi_w_t;

  typedef struct packed {
    logic [c_AXI_ID_W-1:0]   id;
    logic [c_AXI_ADDR_W-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [c_AXI_USER_W-1:0] user;
  } axi_ar_t;

  typedef struct packed {
    logic [c_AXI_ID_W-1:0]   id;
    logic [1:0]              resp;
    logic [c_AXI_USER_W-1:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [c_AXI_ID_W-1:0]   id;
    logic [c_AXI_DATA_W-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [c_AXI_USER_W-1:0] user;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_shim_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_shim_rsp_t;

endpackage
`default_nettype wire

// File: rtl/axi_shim_txn_cnt.sv
`default_nettype none
// ============================================================================
// Module   : axi_shim_txn_cnt
// Desc     : Outstanding-transaction counter (0..Max) with full/nonzero flags.
// Revision : 1.0 - initial release
// ============================================================================
module axi_shim_txn_cnt
  import axi_shim_pkg::*;
#(
  parameter int unsigned Max = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic nonzero_o
);

  localparam int unsigned         c_CNT_W = cnt_width(Max);
  localparam logic [c_CNT_W-1:0]  c_MAX   = c_CNT_W'(Max);

  logic [c_CNT_W-1:0] r_cnt;

  // Simultaneous inc/dec cancel; a stray dec at zero holds the count at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && !dec_i && (r_cnt != c_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (dec_i && !inc_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign full_o    = (r_cnt >= c_MAX);
  assign nonzero_o = (r_cnt != '0);

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && (r_cnt == '0)));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc_i && !dec_i && full_o));

endmodule
`default_nettype wire

// File: rtl/axi_shim_ot.sv
`default_nettype none
// ============================================================================
// Module   : axi_shim_ot
// Desc     : Cache-line AXI master shim with decoupled AW/W and counted
//            outstanding read/write transactions.
// Options  : AXI_SHIM_WRAP_EN adds rd_wrap_i for critical-word-first WRAP reads.
// Revision : 1.0 - initial release
// ============================================================================
module axi_shim_ot
  import axi_shim_pkg::*;
#(
  parameter int unsigned NumWords  = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned MaxWrTxn  = 4,
  parameter int unsigned MaxRdTxn  = 4,
  parameter type axi_req_t = axi_shim_req_t,
  parameter type axi_rsp_t = axi_shim_rsp_t
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  rd_req_i,
  output logic                                  rd_gnt_o,
  input  logic [AddrWidth-1:0]                  rd_addr_i,
  input  logic [blen_width(NumWords)-1:0]       rd_blen_i,
  input  logic [2:0]                            rd_size_i,
  input  logic [IdWidth-1:0]                    rd_id_i,
  input  logic                                  rd_lock_i,
`ifdef AXI_SHIM_WRAP_EN
  input  logic                                  rd_wrap_i,
`endif
  input  logic                                  rd_rdy_i,
  output logic                                  rd_valid_o,
  output logic                                  rd_last_o,
  output logic                                  rd_exokay_o,
  output logic [DataWidth-1:0]                  rd_data_o,
  output logic [UserWidth-1:0]                  rd_user_o,
  output logic [IdWidth-1:0]                    rd_id_o,
  input  logic                                  wr_req_i,
  output logic                                  wr_gnt_o,
  input  logic [AddrWidth-1:0]                  wr_addr_i,
  input  logic [NumWords*DataWidth-1:0]         wr_data_i,
  input  logic [NumWords*UserWidth-1:0]         wr_user_i,
  input  logic [NumWords*DataWidth/8-1:0]       wr_be_i,
  input  logic [blen_width(NumWords)-1:0]       wr_blen_i,
  input  logic [2:0]                            wr_size_i,
  input  logic [IdWidth-1:0]                    wr_id_i,
  input  logic                                  wr_lock_i,
  input  logic [5:0]                            wr_atop_i,
  input  logic                                  wr_rdy_i,
  output logic                                  wr_valid_o,
  output logic                                  wr_exokay_o,
  output logic [IdWidth-1:0]                    wr_id_o,
  output logic                                  wr_busy_o,
  output logic                                  rd_busy_o,
  output axi_req_t                              axi_req_o,
  input  axi_rsp_t                              axi_resp_i
);

  localparam int unsigned c_BLEN_W = blen_width(NumWords);
  localparam int unsigned c_STRB_W = DataWidth / 8;

  logic                r_aw_done;
  logic                r_w_fin;
  logic [c_BLEN_W-1:0] r_beat;

  logic        w_wr_full, w_rd_full;
  logic        w_in_burst, w_wr_ok;
  logic        w_aw_valid, w_w_valid, w_aw_hs, w_w_hs, w_w_last;
  logic        w_wr_gnt, w_b_hs;
  logic        w_ar_valid, w_rd_gnt, w_r_last_hs;
  logic [31:0] w_beat_idx;
  logic [1:0]  w_ar_burst;
  logic        w_unused;

  // Once any part of a burst has been accepted the limit no longer applies.
  assign w_in_burst = r_aw_done | r_w_fin | (r_beat != '0);
  assign w_wr_ok    = wr_req_i & ~rst_i & (~w_wr_full | w_in_burst);
  assign w_aw_valid = w_wr_ok & ~r_aw_done;
  assign w_w_valid  = w_wr_ok & ~r_w_fin;
  assign w_aw_hs    = w_aw_valid & axi_resp_i.aw_ready;
  assign w_w_hs     = w_w_valid & axi_resp_i.w_ready;
  assign w_w_last   = (r_beat == wr_blen_i);
  assign w_wr_gnt   = (r_aw_done | w_aw_hs) & (r_w_fin | (w_w_hs & w_w_last));
  assign w_b_hs     = axi_resp_i.b_valid & wr_rdy_i;
  assign w_beat_idx = 32'(r_beat);

  assign w_ar_valid  = rd_req_i & ~rst_i & ~w_rd_full;
  assign w_rd_gnt    = w_ar_valid & axi_resp_i.ar_ready;
  assign w_r_last_hs = axi_resp_i.r_valid & rd_rdy_i & axi_resp_i.r.last;

`ifdef AXI_SHIM_WRAP_EN
  assign w_ar_burst = (rd_wrap_i && (rd_blen_i != '0)) ? c_BURST_WRAP : c_BURST_INCR;

  a_wrap_len: assert property (@(posedge clk_i) disable iff (rst_i)
    (w_ar_valid && rd_wrap_i && (rd_blen_i != '0)) |->
      ((32'(rd_blen_i) == 1) || (32'(rd_blen_i) == 3) ||
       (32'(rd_blen_i) == 7) || (32'(rd_blen_i) == 15)));
`else
  assign w_ar_burst = c_BURST_INCR;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || w_wr_gnt) begin
      r_aw_done <= 1'b0;
      r_w_fin   <= 1'b0;
      r_beat    <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        if (w_w_last) begin
          r_w_fin <= 1'b1;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
    end
  end

  axi_shim_txn_cnt #(.Max(MaxWrTxn)) u_wr_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (w_wr_gnt),
    .dec_i     (w_b_hs),
    .full_o    (w_wr_full),
    .nonzero_o (wr_busy_o)
  );

  axi_shim_txn_cnt #(.Max(MaxRdTxn)) u_rd_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (w_rd_gnt),
    .dec_i     (w_r_last_hs),
    .full_o    (w_rd_full),
    .nonzero_o (rd_busy_o)
  );

  always_comb begin
    axi_req_o           = '0;
    axi_req_o.aw_valid  = w_aw_valid;
    axi_req_o.aw.id     = wr_id_i;
    axi_req_o.aw.addr   = wr_addr_i;
    axi_req_o.aw.len    = 8'(wr_blen_i);
    axi_req_o.aw.size   = wr_size_i;
    axi_req_o.aw.burst  = c_BURST_INCR;
    axi_req_o.aw.lock   = wr_lock_i;
    axi_req_o.aw.cache  = c_CACHE_MODIFIABLE;
    axi_req_o.aw.atop   = wr_atop_i;
    axi_req_o.w_valid   = w_w_valid;
    axi_req_o.w.data    = wr_data_i[w_beat_idx*DataWidth +: DataWidth];
    axi_req_o.w.strb    = wr_be_i[w_beat_idx*c_STRB_W +: c_STRB_W];
    axi_req_o.w.user    = wr_user_i[w_beat_idx*UserWidth +: UserWidth];
    axi_req_o.w.last    = w_w_last;
    axi_req_o.b_ready   = wr_rdy_i;
    axi_req_o.ar_valid  = w_ar_valid;
    axi_req_o.ar.id     = rd_id_i;
    axi_req_o.ar.addr   = rd_addr_i;
    axi_req_o.ar.len    = 8'(rd_blen_i);
    axi_req_o.ar.size   = rd_size_i;
    axi_req_o.ar.burst  = w_ar_burst;
    axi_req_o.ar.lock   = rd_lock_i;
    axi_req_o.ar.cache  = c_CACHE_MODIFIABLE;
    axi_req_o.r_ready   = rd_rdy_i;
  end

  assign wr_gnt_o    = w_wr_gnt;
  assign rd_gnt_o    = w_rd_gnt;
  assign wr_valid_o  = axi_resp_i.b_valid;
  assign wr_exokay_o = (axi_resp_i.b.resp == c_RESP_EXOKAY);
  assign wr_id_o     = axi_resp_i.b.id;
  assign rd_valid_o  = axi_resp_i.r_valid;
  assign rd_last_o   = axi_resp_i.r.last;
  assign rd_exokay_o = (axi_resp_i.r.resp == c_RESP_EXOKAY);
  assign rd_data_o   = axi_resp_i.r.data;
  assign rd_user_o   = axi_resp_i.r.user;
  assign rd_id_o     = axi_resp_i.r.id;

  assign w_unused = ^axi_resp_i.b.user;

endmodule
`default_nettype wire
